// File: rtl/spi_peripheral_pkg.sv
// Shared constants and state type for the SPI register peripheral.
package spi_peripheral_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;
  localparam int NUM_REGS   = 5;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;
endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection against a one-cycle-delayed copy.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;

  always_comb begin
    sync_d     = {sync_q[STAGES-2:0], d_i};
    prev_d     = sync_q[STAGES-1];
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= {STAGES{RST_VAL}};
      prev_q     <= RST_VAL;
      vld_pipe_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Edges are suppressed until the chain holds only post-reset samples, so the
  // reset value cannot masquerade as a transition on a line held low.
  assign q_o    = sync_q[STAGES-1];
  assign rise_o = vld_pipe_q[STAGES] &  q_o & ~prev_q;
  assign fall_o = vld_pipe_q[STAGES] & ~q_o &  prev_q;
endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register block: 16-bit frames {rw, addr[6:0], data[7:0]}.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);
  logic ncs_rise, ncs_fall, sclk_rise, copi_s;
  logic ncs_lvl_unused, sclk_lvl_unused, sclk_fall_unused;
  logic copi_rise_unused, copi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs),
    .q_o(ncs_lvl_unused), .rise_o(ncs_rise), .fall_o(ncs_fall));

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused));

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi),
    .q_o(copi_s), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused));

  state_e                            state_q, state_d;
  logic [FRAME_BITS-1:0]             sreg_q, sreg_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_REGS-1:0][7:0]          regs_q, regs_d;
  logic [6:0]                        addr;
  logic                              write_ok;

  assign addr     = sreg_q[14:8];
  assign write_ok = (state_q == ST_COMMIT) && (cnt_q == CNT_W'(FRAME_BITS)) &&
                    sreg_q[15] && (addr <= MAX_ADDR) && (addr < 7'(NUM_REGS));

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // Frame end wins over a coincident sclk edge.
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise && (cnt_q < CNT_W'(FRAME_BITS))) begin
          sreg_d = {sreg_q[FRAME_BITS-2:0], copi_s};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        if (write_ok) regs_d[addr[2:0]] = sreg_q[7:0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  assign wr_strobe       = write_ok;
  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[2:0]];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[2:0]];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[2:0]];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[2:0]];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY[2:0]];
endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench: expected writes queued when frames are driven, popped on wr_strobe.
module tb_spi_peripheral;
  logic       clk = 1'b0;
  logic       rst_n, ncs, sclk, copi;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe;

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .wr_strobe(wr_strobe));

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0, n_strobe = 0, n_strobe_exp = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  mdl[5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_r0"}, 32'(r0), 32'(mdl[0]));
    chk({tag, "_r1"}, 32'(r1), 32'(mdl[1]));
    chk({tag, "_r2"}, 32'(r2), 32'(mdl[2]));
    chk({tag, "_r3"}, 32'(r3), 32'(mdl[3]));
    chk({tag, "_r4"}, 32'(r4), 32'(mdl[4]));
  endtask

  // Strobe cycle: retire the oldest expected write into the model.
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      n_strobe++;
      chk("strobe_has_exp", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [10:0] e;
        e = exp_q.pop_front();
        mdl[e[10:8]] = e[7:0];
      end
    end
  end

  task automatic ncs_low();
    ncs = 1'b0;
    wclk(6);
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      wclk(6);
      sclk = 1'b1;
      wclk(6);
      sclk = 1'b0;
    end
  endtask

  task automatic ncs_high(input string tag, input logic exp_wr);
    wclk(6);
    ncs = 1'b1;
    wclk(3);
    chk({tag, "_strobe"}, 32'(wr_strobe), 32'(exp_wr));
    wclk(1);
    chk({tag, "_strobe_off"}, 32'(wr_strobe), 32'd0);
    chk_regs(tag);
    wclk(4);
  endtask

  task automatic frame(input string tag, input logic [31:0] bits, input int n,
                       input logic exp_wr, input logic [2:0] a, input logic [7:0] d);
    if (exp_wr) begin
      exp_q.push_back({a, d});
      n_strobe_exp++;
    end
    ncs_low();
    shift_bits(bits, n);
    ncs_high(tag, exp_wr);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    wclk(3);
    chk_regs("reset");
    chk("reset_strobe", 32'(wr_strobe), 32'd0);
    rst_n = 1'b1;
    wclk(5);

    frame("w00_f0", 32'h80F0, 16, 1'b1, 3'd0, 8'hF0);
    frame("w04_80", 32'h8480, 16, 1'b1, 3'd4, 8'h80);
    frame("w02_01", 32'h8201, 16, 1'b1, 3'd2, 8'h01);
    frame("rd_0455", 32'h0455, 16, 1'b0, 3'd0, 8'h00);
    frame("w05_oor", 32'h8555, 16, 1'b0, 3'd0, 8'h00);
    frame("short10", 32'h0213, 10, 1'b0, 3'd0, 8'h00);
    frame("w01_3c", 32'h813C, 16, 1'b1, 3'd1, 8'h3C);
    frame("long20", {12'h0, 16'h83AA, 4'hF}, 20, 1'b1, 3'd3, 8'hAA);

    for (int k = 0; k < 4; k++) begin
      logic [2:0] a;
      logic [7:0] d;
      a = 3'($urandom_range(0, 4));
      d = 8'($urandom);
      frame("rand", {16'h0, 1'b1, 4'h0, a, d}, 16, 1'b1, a, d);
    end

    // Reset in the middle of a write, ncs held low across it.
    ncs_low();
    shift_bits(32'h80, 8);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    exp_q.delete();
    chk_regs("midrst");
    chk("midrst_strobe", 32'(wr_strobe), 32'd0);
    wclk(2);
    rst_n = 1'b1;
    wclk(2);
    shift_bits(32'h55, 8);
    ncs_high("after_rst", 1'b0);

    frame("post_rst", 32'h8299, 16, 1'b1, 3'd2, 8'h99);

    chk("strobe_count", 32'(n_strobe), 32'(n_strobe_exp));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
